// File: rtl/adder_chk_pkg.sv
// Shared types and helpers for the adder result checker: FSM state encoding,
// default widths, and the reference (golden) sum used by stage 1.
package adder_chk_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_CNT_W = 16;
    localparam int unsigned MAX_WIDTH = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Operands are zero-extended by the caller, so bit WIDTH of the result is the carry.
    function automatic logic [MAX_WIDTH:0] golden_sum(input logic [MAX_WIDTH-1:0] a,
                                                      input logic [MAX_WIDTH-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/adder_chk_golden.sv
// Stage 1 of the checker pipeline: registers an accepted result vector together
// with its WIDTH+1-bit golden sum.
module adder_chk_golden
    import adder_chk_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             accept_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] sum_i,
    input  logic             cout_i,
    output logic             s1_valid_o,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic [WIDTH:0]   golden_o
);

    localparam int unsigned GW = WIDTH + 1;

    logic             s1_valid_q;
    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic             cout_q;
    logic [WIDTH:0]   golden_q;
    logic [WIDTH:0]   golden_d;

    assign golden_d = GW'(golden_sum(MAX_WIDTH'(a_i), MAX_WIDTH'(b_i)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            sum_q      <= '0;
            cout_q     <= 1'b0;
            golden_q   <= '0;
        end else begin
            s1_valid_q <= accept_i;
            if (accept_i) begin
                a_q      <= a_i;
                b_q      <= b_i;
                sum_q    <= sum_i;
                cout_q   <= cout_i;
                golden_q <= golden_d;
            end
        end
    end

    assign s1_valid_o = s1_valid_q;
    assign a_o        = a_q;
    assign b_o        = b_q;
    assign sum_o      = sum_q;
    assign cout_o     = cout_q;
    assign golden_o   = golden_q;

endmodule

// File: rtl/adder_result_checker.sv
// Hardware checker for the adder under test: counts vectors and mismatches per run
// and reports pass/fail. Define FIRST_FAIL_CAPTURE_EN to latch the first failing vector.
module adder_result_checker
    import adder_chk_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned CNT_W     = DEF_CNT_W,
    parameter int unsigned EXP_COUNT = 49
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_sum,
    input  logic             in_cout,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             done,
    output logic             pass,
    output logic             fail_valid,
    output logic [WIDTH-1:0] fail_a,
    output logic [WIDTH-1:0] fail_b,
    output logic [WIDTH-1:0] fail_sum,
    output logic             fail_cout
);

    localparam logic [CNT_W-1:0] EXP_CNT = CNT_W'(EXP_COUNT);
    localparam logic [CNT_W-1:0] ERR_MAX = '1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] vec_cnt_q, vec_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             in_ready_q, in_ready_d;

    logic             accept;
    logic             mismatch;
    logic             s1_valid;
    logic [WIDTH-1:0] s1_a, s1_b, s1_sum;
    logic             s1_cout;
    logic [WIDTH:0]   s1_golden;

    assign accept = in_valid & in_ready_q;

    adder_chk_golden #(
        .WIDTH (WIDTH)
    ) u_golden (
        .clk        (clk),
        .rst        (rst),
        .accept_i   (accept),
        .a_i        (in_a),
        .b_i        (in_b),
        .sum_i      (in_sum),
        .cout_i     (in_cout),
        .s1_valid_o (s1_valid),
        .a_o        (s1_a),
        .b_o        (s1_b),
        .sum_o      (s1_sum),
        .cout_o     (s1_cout),
        .golden_o   (s1_golden)
    );

    // Stage 2: the carry is part of the compare, so a carry-only error counts.
    assign mismatch = s1_valid & ({s1_cout, s1_sum} != s1_golden);

    always_comb begin
        state_d   = state_q;
        vec_cnt_d = vec_cnt_q;
        err_cnt_d = err_cnt_q;
        done_d    = done_q;
        pass_d    = pass_q;

        if (mismatch && (err_cnt_q != ERR_MAX)) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d   = ST_RUN;
                    vec_cnt_d = '0;
                    err_cnt_d = '0;
                    done_d    = 1'b0;
                    pass_d    = 1'b0;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    vec_cnt_d = vec_cnt_q + CNT_W'(1);
                    if (vec_cnt_d == EXP_CNT) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // err_cnt_q is final once stage 1 has emptied.
                if (!s1_valid) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    pass_d  = (err_cnt_q == '0) && (vec_cnt_q == EXP_CNT);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        in_ready_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            vec_cnt_q  <= '0;
            err_cnt_q  <= '0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            vec_cnt_q  <= vec_cnt_d;
            err_cnt_q  <= err_cnt_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready = in_ready_q;
    assign vec_cnt  = vec_cnt_q;
    assign err_cnt  = err_cnt_q;
    assign done     = done_q;
    assign pass     = pass_q;

`ifdef FIRST_FAIL_CAPTURE_EN
    logic             fail_valid_q;
    logic [WIDTH-1:0] fail_a_q, fail_b_q, fail_sum_q;
    logic             fail_cout_q;

    // First mismatch of a run wins; cleared when a new run begins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fail_valid_q <= 1'b0;
            fail_a_q     <= '0;
            fail_b_q     <= '0;
            fail_sum_q   <= '0;
            fail_cout_q  <= 1'b0;
        end else if ((state_q != ST_RUN) && (state_d == ST_RUN)) begin
            fail_valid_q <= 1'b0;
            fail_a_q     <= '0;
            fail_b_q     <= '0;
            fail_sum_q   <= '0;
            fail_cout_q  <= 1'b0;
        end else if (mismatch && !fail_valid_q) begin
            fail_valid_q <= 1'b1;
            fail_a_q     <= s1_a;
            fail_b_q     <= s1_b;
            fail_sum_q   <= s1_sum;
            fail_cout_q  <= s1_cout;
        end
    end

    assign fail_valid = fail_valid_q;
    assign fail_a     = fail_a_q;
    assign fail_b     = fail_b_q;
    assign fail_sum   = fail_sum_q;
    assign fail_cout  = fail_cout_q;
`else
    logic unused_s1_operands;
    assign unused_s1_operands = ^{s1_a, s1_b};

    assign fail_valid = 1'b0;
    assign fail_a     = '0;
    assign fail_b     = '0;
    assign fail_sum   = '0;
    assign fail_cout  = 1'b0;
`endif

endmodule

// File: tb/tb_adder_result_checker.sv
// Directed bench for adder_result_checker: three instances (2-vector runs, default
// 49-vector runs, 4-bit counters) share the vector bus but have separate start pulses.
module tb_adder_result_checker;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sum;
        logic        cout;
    } vec_t;

    typedef struct {
        int          i0;
        int          i1;
        int          err_mid;
        int          err_fin;
        logic        pass;
        logic        fail_valid;
        logic [31:0] fail_a;
    } run_t;

    logic        clk;
    logic        rst;
    logic        start_2, start_49, start_s;
    logic        in_valid;
    logic [31:0] in_a, in_b, in_sum;
    logic        in_cout;

    logic        rdy2, done2, pass2, fv2, fc2;
    logic [15:0] vc2, ec2;
    logic [31:0] fa2, fb2, fs2;

    logic        rdy49, done49, pass49, fv49, fc49;
    logic [15:0] vc49, ec49;
    logic [31:0] fa49, fb49, fs49;

    logic        rdys, dones, passs, fvs, fcs;
    logic [3:0]  vcs, ecs;
    logic [31:0] fas, fbs, fss;

    int n_total;
    int n_bad;

    vec_t vecs[8];
    run_t runs[6];
    int   good_idx[5];

    adder_result_checker #(.WIDTH(32), .CNT_W(16), .EXP_COUNT(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start_2), .in_valid(in_valid), .in_ready(rdy2),
        .in_a(in_a), .in_b(in_b), .in_sum(in_sum), .in_cout(in_cout),
        .vec_cnt(vc2), .err_cnt(ec2), .done(done2), .pass(pass2),
        .fail_valid(fv2), .fail_a(fa2), .fail_b(fb2), .fail_sum(fs2), .fail_cout(fc2)
    );

    adder_result_checker #(.WIDTH(32), .CNT_W(16), .EXP_COUNT(49)) u_dut49 (
        .clk(clk), .rst(rst), .start(start_49), .in_valid(in_valid), .in_ready(rdy49),
        .in_a(in_a), .in_b(in_b), .in_sum(in_sum), .in_cout(in_cout),
        .vec_cnt(vc49), .err_cnt(ec49), .done(done49), .pass(pass49),
        .fail_valid(fv49), .fail_a(fa49), .fail_b(fb49), .fail_sum(fs49), .fail_cout(fc49)
    );

    adder_result_checker #(.WIDTH(32), .CNT_W(4), .EXP_COUNT(15)) u_sat (
        .clk(clk), .rst(rst), .start(start_s), .in_valid(in_valid), .in_ready(rdys),
        .in_a(in_a), .in_b(in_b), .in_sum(in_sum), .in_cout(in_cout),
        .vec_cnt(vcs), .err_cnt(ecs), .done(dones), .pass(passs),
        .fail_valid(fvs), .fail_a(fas), .fail_b(fbs), .fail_sum(fss), .fail_cout(fcs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic apply(input vec_t v);
        in_a    = v.a;
        in_b    = v.b;
        in_sum  = v.sum;
        in_cout = v.cout;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_total = 0;
        n_bad   = 0;

        // Vector table: good/bad is hand-computed from the true 33-bit sum.
        vecs[0] = '{32'h00000001, 32'h00000001, 32'h00000002, 1'b0}; // good
        vecs[1] = '{32'hFFFF0006, 32'h12560006, 32'h1255000C, 1'b1}; // good
        vecs[2] = '{32'hAAAA0004, 32'hABCD0004, 32'h00000000, 1'b0}; // bad
        vecs[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0}; // bad (carry only)
        vecs[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1}; // good
        vecs[5] = '{32'h12345678, 32'h11111111, 32'h00000000, 1'b0}; // bad
        vecs[6] = '{32'h80000000, 32'h80000000, 32'h00000000, 1'b1}; // good
        vecs[7] = '{32'h00000000, 32'h00000000, 32'h00000000, 1'b0}; // good

        runs[0] = '{0, 1, 0, 0, 1'b1, 1'b0, 32'h00000000};
        runs[1] = '{2, 0, 1, 1, 1'b0, 1'b1, 32'hAAAA0004};
        runs[2] = '{2, 5, 1, 2, 1'b0, 1'b1, 32'hAAAA0004};
        runs[3] = '{3, 4, 1, 1, 1'b0, 1'b1, 32'hFFFFFFFF};
        runs[4] = '{4, 6, 0, 0, 1'b1, 1'b0, 32'h00000000};
        runs[5] = '{7, 3, 0, 1, 1'b0, 1'b1, 32'hFFFFFFFF};

        good_idx[0] = 0; good_idx[1] = 1; good_idx[2] = 4; good_idx[3] = 6; good_idx[4] = 7;

        rst = 1'b1;
        start_2 = 1'b0; start_49 = 1'b0; start_s = 1'b0;
        in_valid = 1'b0;
        apply(vecs[7]);
        repeat (3) @(negedge clk);
        chk("reset in_ready", 64'(rdy2), 64'd0);
        chk("reset vec_cnt", 64'(vc2), 64'd0);
        chk("reset err_cnt", 64'(ec2), 64'd0);
        chk("reset done", 64'(done2), 64'd0);
        chk("reset pass", 64'(pass2), 64'd0);
        chk("reset fail_valid", 64'(fv2), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // in_valid while IDLE is ignored.
        apply(vecs[2]);
        in_valid = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle in_ready", 64'(rdy2), 64'd0);
        chk("idle vec_cnt", 64'(vc2), 64'd0);
        chk("idle err_cnt", 64'(ec2), 64'd0);
        in_valid = 1'b0;

        // Two-vector runs with exact pipeline timing.
        for (int r = 0; r < 6; r++) begin
            start_2 = 1'b1;
            @(negedge clk);
            start_2 = 1'b0;
            chk($sformatf("run%0d in_ready", r), 64'(rdy2), 64'd1);
            chk($sformatf("run%0d cleared done", r), 64'(done2), 64'd0);
            apply(vecs[runs[r].i0]);
            in_valid = 1'b1;
            @(negedge clk);
            chk($sformatf("run%0d vec_cnt1", r), 64'(vc2), 64'd1);
            chk($sformatf("run%0d err_cnt0", r), 64'(ec2), 64'd0);
            apply(vecs[runs[r].i1]);
            @(negedge clk);
            in_valid = 1'b0;
            chk($sformatf("run%0d vec_cnt2", r), 64'(vc2), 64'd2);
            chk($sformatf("run%0d drain ready", r), 64'(rdy2), 64'd0);
            chk($sformatf("run%0d err_mid", r), 64'(ec2), 64'(runs[r].err_mid));
            @(negedge clk);
            chk($sformatf("run%0d err_fin", r), 64'(ec2), 64'(runs[r].err_fin));
            chk($sformatf("run%0d done early", r), 64'(done2), 64'd0);
            @(negedge clk);
            chk($sformatf("run%0d done", r), 64'(done2), 64'd1);
            chk($sformatf("run%0d pass", r), 64'(pass2), 64'(runs[r].pass));
`ifdef FIRST_FAIL_CAPTURE_EN
            chk($sformatf("run%0d fail_valid", r), 64'(fv2), 64'(runs[r].fail_valid));
            chk($sformatf("run%0d fail_a", r), 64'(fa2), 64'(runs[r].fail_a));
`else
            chk($sformatf("run%0d fail_valid", r), 64'(fv2), 64'd0);
            chk($sformatf("run%0d fail_a", r), 64'(fa2), 64'd0);
`endif
        end

        // in_valid while DONE is ignored; results held.
        apply(vecs[2]);
        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        chk("done in_ready", 64'(rdy2), 64'd0);
        chk("done vec_cnt held", 64'(vc2), 64'd2);
        chk("done err_cnt held", 64'(ec2), 64'd1);
        chk("done held", 64'(done2), 64'd1);

        // Saturation with 4-bit counters.
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        apply(vecs[2]);
        in_valid = 1'b1;
        repeat (15) @(negedge clk);
        in_valid = 1'b0;
        chk("sat vec_cnt", 64'(vcs), 64'd15);
        chk("sat in_ready", 64'(rdys), 64'd0);
        repeat (2) @(negedge clk);
        chk("sat err_cnt", 64'(ecs), 64'hF);
        chk("sat done", 64'(dones), 64'd1);
        chk("sat pass", 64'(passs), 64'd0);
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        apply(vecs[3]);
        in_valid = 1'b1;
        repeat (16) @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("sat2 err_cnt", 64'(ecs), 64'hF);
        chk("sat2 vec_cnt", 64'(vcs), 64'd15);
        chk("sat2 done", 64'(dones), 64'd1);

        // Asynchronous reset one cycle after an accept.
        start_49 = 1'b1;
        @(negedge clk);
        start_49 = 1'b0;
        apply(vecs[2]);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("pre-rst vec_cnt", 64'(vc49), 64'd1);
        #1 rst = 1'b1;
        #1;
        chk("async rst vec_cnt", 64'(vc49), 64'd0);
        chk("async rst in_ready", 64'(rdy49), 64'd0);
        chk("async rst err_cnt", 64'(ec49), 64'd0);
        chk("async rst fail_valid", 64'(fv49), 64'd0);
        chk("async rst done2", 64'(done2), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post-rst err_cnt", 64'(ec49), 64'd0);
        chk("post-rst done", 64'(done49), 64'd0);

        // Full 49-vector clean run, with a start pulse mid-run that must be ignored.
        start_49 = 1'b1;
        @(negedge clk);
        start_49 = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 49; i++) begin
            if (i == 12) chk("mid-run start ignored", 64'(vc49), 64'd12);
            apply(vecs[good_idx[i % 5]]);
            start_49 = (i == 10);
            @(negedge clk);
        end
        in_valid = 1'b0;
        start_49 = 1'b0;
        chk("run49 vec_cnt", 64'(vc49), 64'd49);
        chk("run49 in_ready", 64'(rdy49), 64'd0);
        @(negedge clk);
        chk("run49 done early", 64'(done49), 64'd0);
        for (int k = 0; k < 10 && !done49; k++) @(negedge clk);
        chk("run49 done", 64'(done49), 64'd1);
        chk("run49 err_cnt", 64'(ec49), 64'd0);
        chk("run49 pass", 64'(pass49), 64'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
